// File: rtl/mainbus_pkg.sv
// Shared types and default sizes for the main-bus arbiter slice.
// Holds the ownership state enum and the hold-counter width.
package mainbus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int DEF_NUM_SRC = 3;
    localparam int DEF_DATA_W  = 32;
    localparam int HOLD_W      = 8;

endpackage

// File: rtl/mainbus_pick.sv
// Combinational winner search over a request mask: lowest index, or circular from start_idx.
// Zero latency; no backpressure, found is low when the mask is empty.
module mainbus_pick
    import mainbus_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_mask,
    input  logic [IDX_W-1:0]   start_idx,
    input  logic               rr_mode,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        win_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // start_idx is always < NUM_SRC, so one subtraction wraps the sum
            cand = rr_mode ? int'(start_idx) + i : i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_mask[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mainbus_arbiter.sv
// Main-bus arbiter: grants one source, registers its data, bounds locked ownership to MAX_HOLD cycles.
// Latency 1 cycle request-to-grant; sources are never stalled, losers simply keep requesting.
module mainbus_arbiter
    import mainbus_pkg::*;
#(
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RR_EN    = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req_i,
    input  logic [NUM_SRC-1:0]            lock_i,
    input  logic [NUM_SRC*DATA_W-1:0]     data_i,
    output logic [NUM_SRC-1:0]            gnt_o,
    output logic [DATA_W-1:0]             bus_data_o,
    output logic                          bus_valid_o,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] owner_o,
    output logic                          timeout_o
);

    localparam int                IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_SRC - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_SRC-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                timeout_q, timeout_d;

    logic [DATA_W-1:0]   src_dat [NUM_SRC];
    logic [NUM_SRC-1:0]  pick_mask;
    logic [IDX_W-1:0]    start_idx;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                owner_locked;
    logic                owner_keep;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_dat[k] = data_i[k*DATA_W +: DATA_W];
    end

    assign start_idx    = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    assign owner_locked = (state_q == OWNED) && req_i[owner_q] && lock_i[owner_q];
    assign owner_keep   = owner_locked && (hold_q < MAX_HOLD_C);

    // A forced release takes the expiring owner out of this edge's search only
    always_comb begin
        pick_mask = req_i;
        if (owner_locked) begin
            pick_mask[owner_q] = 1'b0;
        end
    end

    mainbus_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_mask  (pick_mask),
        .start_idx (start_idx),
        .rr_mode   (RR_EN != 0),
        .win_idx   (win_idx),
        .found     (win_found)
    );

    always_comb begin
        state_d   = IDLE;
        owner_d   = '0;
        last_d    = last_q;
        hold_d    = '0;
        gnt_d     = '0;
        data_d    = '0;
        timeout_d = 1'b0;
        if (owner_keep) begin
            state_d = OWNED;
            owner_d = owner_q;
            hold_d  = hold_q + 1'b1;
            gnt_d   = gnt_q;
            data_d  = src_dat[owner_q];
        end else begin
            timeout_d = owner_locked;
            if (win_found) begin
                state_d        = OWNED;
                owner_d        = win_idx;
                last_d         = win_idx;
                hold_d         = HOLD_W'(1);
                gnt_d[win_idx] = 1'b1;
                data_d         = src_dat[win_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= LAST_IDX;
            hold_q    <= '0;
            gnt_q     <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign bus_data_o  = data_q;
    assign bus_valid_o = (state_q == OWNED);
    assign owner_o     = owner_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Bench for mainbus_arbiter: a fixed-priority and a round-robin instance on shared stimulus.
module tb_mainbus_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [31:0] sd [3];
    logic [95:0] data;

    logic [2:0]  gnt_fp, gnt_rr;
    logic [1:0]  own_fp, own_rr;
    logic [31:0] dat_fp, dat_rr;
    logic        vld_fp, vld_rr, to_fp, to_rr;

    int n_chk  = 0;
    int n_pass = 0;

    // model state, index 0 = fixed priority, 1 = round-robin
    int          m_own [2];
    int          m_hold[2];
    int          m_last[2];
    logic        m_to  [2];
    logic [31:0] m_dat [2];

    assign data = {sd[2], sd[1], sd[0]};

    always #5 clk = ~clk;

    mainbus_arbiter #(.NUM_SRC(3), .DATA_W(32), .RR_EN(0), .MAX_HOLD(HOLD)) u_fp (
        .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .data_i(data),
        .gnt_o(gnt_fp), .bus_data_o(dat_fp), .bus_valid_o(vld_fp),
        .owner_o(own_fp), .timeout_o(to_fp)
    );

    mainbus_arbiter #(.NUM_SRC(3), .DATA_W(32), .RR_EN(1), .MAX_HOLD(HOLD)) u_rr (
        .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .data_i(data),
        .gnt_o(gnt_rr), .bus_data_o(dat_rr), .bus_valid_o(vld_rr),
        .owner_o(own_rr), .timeout_o(to_rr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; lock = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // One edge of the arbitration rules, written from ownership and priority order directly.
    function automatic void model_step(input logic r);
        for (int m = 0; m < 2; m++) begin
            int ex, w, c;
            ex = -1; w = -1;
            m_to[m] = 1'b0;
            if (r) begin
                m_own[m] = -1; m_hold[m] = 0; m_last[m] = 2; m_dat[m] = '0;
            end else if (m_own[m] >= 0 && req[m_own[m]] && lock[m_own[m]] && m_hold[m] < HOLD) begin
                m_hold[m]++;
                m_dat[m] = sd[m_own[m]];
            end else begin
                if (m_own[m] >= 0 && req[m_own[m]] && lock[m_own[m]]) begin
                    m_to[m] = 1'b1;
                    ex = m_own[m];
                end
                for (int i = 0; i < 3; i++) begin
                    c = (m == 1) ? (m_last[m] + 1 + i) % 3 : i;
                    if (w < 0 && req[c] && c != ex) w = c;
                end
                m_own[m] = w;
                if (w >= 0) begin
                    m_hold[m] = 1; m_last[m] = w; m_dat[m] = sd[w];
                end else begin
                    m_hold[m] = 0; m_dat[m] = '0;
                end
            end
        end
    endfunction

    function automatic logic [38:0] model_vec(input int m);
        logic [2:0] g;
        logic [1:0] o;
        g = '0; o = '0;
        if (m_own[m] >= 0) begin
            g[m_own[m]] = 1'b1;
            o = 2'(m_own[m]);
        end
        return {g, o, (m_own[m] >= 0), m_to[m], m_dat[m]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; lock = 3'b111;
        sd[0] = 32'h1111_1111; sd[1] = 32'h2222_2222; sd[2] = 32'h3333_3333;
        tick(); tick();
        n_chk++;
        if ({gnt_fp, own_fp, vld_fp, to_fp, dat_fp} !== 39'd0)
            $display("FAIL reset_fp got gnt=%b own=%0d vld=%b to=%b dat=%h want all zero", gnt_fp, own_fp, vld_fp, to_fp, dat_fp);
        else n_pass++;
        n_chk++;
        if ({gnt_rr, own_rr, vld_rr, to_rr, dat_rr} !== 39'd0)
            $display("FAIL reset_rr got gnt=%b own=%0d vld=%b to=%b dat=%h want all zero", gnt_rr, own_rr, vld_rr, to_rr, dat_rr);
        else n_pass++;
        rst = 1'b0; req = '0; lock = '0;
        tick();
        n_chk++;
        if ({gnt_fp, vld_fp, gnt_rr, vld_rr} !== 8'd0)
            $display("FAIL idle_no_req got fp=%b/%b rr=%b/%b want 000/0", gnt_fp, vld_fp, gnt_rr, vld_rr);
        else n_pass++;
    endtask

    task automatic test_first_grant();
        do_reset();
        sd[0] = 32'h0BAD_0000; sd[1] = 32'hA5A5_0001; sd[2] = 32'hC3C3_0002;
        req = 3'b110; lock = 3'b000;
        tick();
        n_chk++;
        if ({gnt_fp, own_fp, vld_fp, dat_fp} !== {3'b010, 2'd1, 1'b1, 32'hA5A5_0001})
            $display("FAIL first_grant_fp got gnt=%b own=%0d vld=%b dat=%h want 010/1/1/a5a50001", gnt_fp, own_fp, vld_fp, dat_fp);
        else n_pass++;
        n_chk++;
        if ({gnt_rr, own_rr, vld_rr, dat_rr} !== {3'b010, 2'd1, 1'b1, 32'hA5A5_0001})
            $display("FAIL first_grant_rr got gnt=%b own=%0d vld=%b dat=%h want 010/1/1/a5a50001", gnt_rr, own_rr, vld_rr, dat_rr);
        else n_pass++;
        tick();
        n_chk++;
        if ({gnt_fp, own_fp, dat_fp} !== {3'b010, 2'd1, 32'hA5A5_0001})
            $display("FAIL second_grant_fp got gnt=%b own=%0d dat=%h want 010/1/a5a50001", gnt_fp, own_fp, dat_fp);
        else n_pass++;
        n_chk++;
        if ({gnt_rr, own_rr, dat_rr} !== {3'b100, 2'd2, 32'hC3C3_0002})
            $display("FAIL second_grant_rr got gnt=%b own=%0d dat=%h want 100/2/c3c30002", gnt_rr, own_rr, dat_rr);
        else n_pass++;
    endtask

    task automatic test_rr_rotation();
        do_reset();
        for (int k = 0; k < 3; k++) sd[k] = 32'h100 + k;
        req = 3'b111; lock = 3'b000;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_chk++;
            if ({vld_rr, own_rr, dat_rr} !== {1'b1, 2'(c % 3), 32'h100 + 32'(c % 3)})
                $display("FAIL rr_rotation cyc%0d got vld=%b own=%0d dat=%h want 1/%0d", c, vld_rr, own_rr, dat_rr, c % 3);
            else n_pass++;
            n_chk++;
            if ({vld_fp, gnt_fp} !== 4'b1001)
                $display("FAIL fp_all_req cyc%0d got vld=%b gnt=%b want 1/001", c, vld_fp, gnt_fp);
            else n_pass++;
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        sd[0] = 32'hF00D_0000; sd[1] = 32'hDEAD_BEEF; sd[2] = 32'hF00D_0002;
        req = 3'b101; lock = 3'b000;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if ({gnt_fp, own_fp, vld_fp, dat_fp} !== {3'b001, 2'd0, 1'b1, 32'hF00D_0000})
                $display("FAIL fixed_prio cyc%0d got gnt=%b own=%0d vld=%b dat=%h want 001/0/1/f00d0000", c, gnt_fp, own_fp, vld_fp, dat_fp);
            else n_pass++;
        end
    endtask

    task automatic test_hold_timeout();
        do_reset();
        sd[0] = 32'h0; sd[1] = 32'h1111_0001; sd[2] = 32'h2222_0002;
        req = 3'b110; lock = 3'b010;
        for (int c = 0; c < 6; c++) begin
            logic [1:0] eo;
            logic       et;
            tick();
            eo = (c < HOLD) ? 2'd1 : (c == HOLD) ? 2'd2 : 2'd1;
            et = (c == HOLD);
            n_chk++;
            if ({own_fp, to_fp, vld_fp} !== {eo, et, 1'b1})
                $display("FAIL hold_fp cyc%0d got own=%0d to=%b vld=%b want own=%0d to=%b", c, own_fp, to_fp, vld_fp, eo, et);
            else n_pass++;
            n_chk++;
            if ({own_rr, to_rr, vld_rr} !== {eo, et, 1'b1})
                $display("FAIL hold_rr cyc%0d got own=%0d to=%b vld=%b want own=%0d to=%b", c, own_rr, to_rr, vld_rr, eo, et);
            else n_pass++;
        end
        lock = 3'b000;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        sd[0] = 32'hAAAA_0000; sd[1] = 32'hBBBB_0001; sd[2] = 32'hCCCC_0002;
        req = 3'b001; lock = 3'b001;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_chk++;
        if ({gnt_rr, own_rr, vld_rr, to_rr, dat_rr, gnt_fp, vld_fp} !== 43'd0)
            $display("FAIL reset_mid_lock got rr gnt=%b own=%0d vld=%b dat=%h fp gnt=%b want zero", gnt_rr, own_rr, vld_rr, dat_rr, gnt_fp);
        else n_pass++;
        rst = 1'b0; req = 3'b011; lock = 3'b000;
        tick();
        n_chk++;
        if ({gnt_rr, own_rr, dat_rr} !== {3'b001, 2'd0, 32'hAAAA_0000})
            $display("FAIL rr_after_reset got gnt=%b own=%0d dat=%h want 001/0/aaaa0000", gnt_rr, own_rr, dat_rr);
        else n_pass++;
        tick();
        n_chk++;
        if (own_rr !== 2'd1)
            $display("FAIL rr_after_reset_next got own=%0d want 1", own_rr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [38:0] ev;
        rst = 1'b1; req = '0; lock = '0;
        model_step(1'b1);
        tick();
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 3; k++) begin
                req[k]  = ($urandom_range(0, 9) < 6);
                lock[k] = ($urandom_range(0, 9) < 8);
                sd[k]   = $urandom;
            end
            model_step(rst);
            tick();
            ev = model_vec(0);
            n_chk++;
            if ({gnt_fp, own_fp, vld_fp, to_fp, dat_fp} !== ev)
                $display("FAIL random_fp cyc%0d got %h want %h", c, {gnt_fp, own_fp, vld_fp, to_fp, dat_fp}, ev);
            else n_pass++;
            ev = model_vec(1);
            n_chk++;
            if ({gnt_rr, own_rr, vld_rr, to_rr, dat_rr} !== ev)
                $display("FAIL random_rr cyc%0d got %h want %h", c, {gnt_rr, own_rr, vld_rr, to_rr, dat_rr}, ev);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0;
        for (int k = 0; k < 3; k++) sd[k] = '0;
        test_reset();
        test_first_grant();
        test_rr_rotation();
        test_fixed_priority();
        test_hold_timeout();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
